seg7_scan_driver: RTL and testbench

- Downstream consumer of the BCD converter.
- Latches the converter's tens/ones digits, a sign flag and the 3-bit function code.
- Time-multiplexes them onto a 4-digit common-anode 7-segment display: active-low anodes, active-low segments.
- Double-buffered, so a new value never appears partway through a scan frame.

---
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Latches BCD tens/ones digits, a sign flag and a 3-bit
//                function code, then time-multiplexes them onto a 4-digit
//                common-anode 7-segment display (active-low anodes and
//                segments). Double-buffered: a pending register collects
//                loads and is copied to the shadow register only at the
//                frame boundary, so a frame never shows a mixed value.
//  Options     : SEG7_LZ_BLANK_EN - when defined, a shadow tens digit of 0
//                is blanked while its anode still scans.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       neg,
    input  logic [2:0] f,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    // Prescaler width; at least one bit so REFRESH_DIV=2 still works.
    localparam int c_PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_MINUS = 7'b0111111;

    // Packed display word layout: {tens[11:8], ones[7:4], neg[3], f[2:0]}
    logic [c_PRE_W-1:0] r_pre;
    logic [1:0]         r_idx;
    logic [11:0]        r_pend;
    logic [11:0]        r_shad;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_fs;

    logic               w_tick;
    logic               w_frame_end;
    logic [6:0]         w_digit_seg;

    // Full hex decode to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick      = (r_pre == c_PRE_MAX);
    assign w_frame_end = w_tick && (r_idx == 2'd3);

    // Prescaler and digit index: each digit holds for REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else begin
            if (w_tick) begin
                r_pre <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    // Pending register: the most recent load within a frame wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (ld) begin
            r_pend <= {tens, ones, neg, f};
        end
    end

    // Shadow register: copied from pending at the end of the last digit slot,
    // so a load on that same edge lands one frame later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shad <= '0;
            r_fs   <= 1'b0;
        end else begin
            r_fs <= w_frame_end;
            if (w_frame_end) begin
                r_shad <= r_pend;
            end
        end
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        w_digit_seg = c_SEG_BLANK;
        case (r_idx)
            2'd0: w_digit_seg = hex7(r_shad[7:4]);
`ifdef SEG7_LZ_BLANK_EN
            2'd1: w_digit_seg = (r_shad[11:8] == 4'd0) ? c_SEG_BLANK : hex7(r_shad[11:8]);
`else
            2'd1: w_digit_seg = hex7(r_shad[11:8]);
`endif
            2'd2: w_digit_seg = r_shad[3] ? c_SEG_MINUS : c_SEG_BLANK;
            default: w_digit_seg = hex7({1'b0, r_shad[2:0]});
        endcase
    end

    // Registered display drive; lags the scan index by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= c_SEG_BLANK;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_digit_seg;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = 1'b1;
    assign frame_start = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver with REFRESH_DIV=4.
//                Per-cycle expected display states are queued and compared
//                against the outputs one cycle after each driven edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    localparam int RD = 4;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] TENS0 = 7'b1111111;
`else
    localparam logic [6:0] TENS0 = 7'b1000000;
`endif
    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       neg = 1'b0;
    logic [2:0] f = 3'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    seg7_scan_driver #(.REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld          (ld),
        .tens        (tens),
        .ones        (ones),
        .neg         (neg),
        .f           (f),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } obs_t;

    typedef struct {
        int         j;
        logic [3:0] t;
        logic [3:0] o;
        logic       n;
        logic [2:0] fc;
    } ldev_t;

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       n;
        logic [2:0] fc;
        logic [6:0] e_o;
        logic [6:0] e_t;
        logic [6:0] e_s;
        logic [6:0] e_f;
    } vec_t;

    obs_t  sb[$];
    ldev_t sched[$];
    vec_t  vt[5];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check_pop(input string nm);
        obs_t e;
        e = sb.pop_front();
        n_vec++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_start !== e.fs) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
                     nm, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
        end
    endtask

    // Held reset: display dark, no frame pulse.
    task automatic reset_cycles(input int n);
        obs_t o;
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            o.an = 4'b1111; o.seg = BLANK; o.dp = 1'b1; o.fs = 1'b0;
            sb.push_back(o);
            @(posedge clk); #1;
            check_pop($sformatf("reset_c%0d", k));
        end
    endtask

    // One frame (or its first ncyc cycles) with the given per-slot segments;
    // any scheduled loads are applied before the edge of their cycle index.
    task automatic run_frame(input string nm, input logic [6:0] e_o, input logic [6:0] e_t,
                             input logic [6:0] e_s, input logic [6:0] e_f, input int ncyc);
        logic [6:0] ex[4];
        obs_t       o;
        ldev_t      l;
        ex[0] = e_o; ex[1] = e_t; ex[2] = e_s; ex[3] = e_f;
        for (int j = 0; j < ncyc; j++) begin
            o.an  = ~(4'b0001 << (j / RD));
            o.seg = ex[j / RD];
            o.dp  = 1'b1;
            o.fs  = (j == 4 * RD - 1);
            sb.push_back(o);
            ld = 1'b0;
            if (sched.size() > 0 && sched[0].j == j) begin
                l = sched.pop_front();
                ld = 1'b1; tens = l.t; ones = l.o; neg = l.n; f = l.fc;
            end
            @(posedge clk); #1;
            ld = 1'b0;
            check_pop($sformatf("%s_c%0d", nm, j));
        end
    endtask

    initial begin
        vt[0] = '{4'd0,  4'd4,  1'b0, 3'd0, 7'b0011001, TENS0,      BLANK, 7'b1000000};
        vt[1] = '{4'd10, 4'd11, 1'b1, 3'd6, 7'b0000011, 7'b0001000, MINUS, 7'b0000010};
        vt[2] = '{4'd12, 4'd13, 1'b0, 3'd4, 7'b0100001, 7'b1000110, BLANK, 7'b0011001};
        vt[3] = '{4'd14, 4'd15, 1'b1, 3'd1, 7'b0001110, 7'b0000110, MINUS, 7'b1111001};
        vt[4] = '{4'd3,  4'd6,  1'b0, 3'd2, 7'b0000010, 7'b0110000, BLANK, 7'b0100100};

        // Reset held for three cycles, then free-running with zero value.
        reset_cycles(3);
        rst_n = 1'b1;
        run_frame("free0", S0, TENS0, BLANK, S0, 4 * RD);
        run_frame("free1", S0, TENS0, BLANK, S0, 4 * RD);

        // Mid-frame load appears only in the following frame.
        sched.push_back('{6, 4'd1, 4'd5, 1'b1, 3'd3});
        run_frame("ldmid", S0, TENS0, BLANK, S0, 4 * RD);
        run_frame("show15", 7'b0010010, 7'b1111001, MINUS, 7'b0110000, 4 * RD);

        // Two loads in a frame (last wins) plus a load on the shadow-load edge.
        sched.push_back('{2,  4'd2, 4'd7, 1'b0, 3'd5});
        sched.push_back('{9,  4'd2, 4'd2, 1'b0, 3'd5});
        sched.push_back('{15, 4'd9, 4'd8, 1'b1, 3'd7});
        run_frame("multild", 7'b0010010, 7'b1111001, MINUS, 7'b0110000, 4 * RD);
        run_frame("lastwins", 7'b0100100, 7'b0100100, BLANK, 7'b0010010, 4 * RD);

        // Boundary value shows one frame late; table vectors chain after it.
        sched.push_back('{5, vt[0].t, vt[0].o, vt[0].n, vt[0].fc});
        run_frame("boundary", 7'b0000000, 7'b0010000, MINUS, 7'b1111000, 4 * RD);
        for (int i = 1; i < 5; i++) begin
            sched.push_back('{5, vt[i].t, vt[i].o, vt[i].n, vt[i].fc});
            run_frame($sformatf("vec%0d", i - 1), vt[i-1].e_o, vt[i-1].e_t, vt[i-1].e_s, vt[i-1].e_f, 4 * RD);
        end
        run_frame("vec4", vt[4].e_o, vt[4].e_t, vt[4].e_s, vt[4].e_f, 4 * RD);

        // Reset while the sign digit is lit, then scan restarts from zero.
        run_frame("prerst", vt[4].e_o, vt[4].e_t, vt[4].e_s, vt[4].e_f, 2 * RD + 1);
        reset_cycles(1);
        rst_n = 1'b1;
        run_frame("postrst0", S0, TENS0, BLANK, S0, 4 * RD);
        run_frame("postrst1", S0, TENS0, BLANK, S0, 4 * RD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
